// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low {g..a} patterns for the result displays.
package seg_pkg;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = 7'h7F;

  // Indexed by code; entries 10..15 are the A, b, C, d, E, F glyphs.
  localparam seg_code_t SEG_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decoder.sv
// Combinational code-to-segment decoder; invalid entries and, without hex_en,
// codes 10..15 are blanked.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       valid,
  input  logic       hex_en,
  output seg_code_t  seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (valid && (hex_en || (code < 4'd10))) begin
      seg = SEG_PATTERN[code];
    end
  end

endmodule

// File: rtl/result_display_mux.sv
// Multi-digit scanned 7-segment display of the last NUM_DIGITS classification results,
// with hold, clear and a saturating dropped-result counter.
module result_display_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned HEX_EN      = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              result_valid,
  input  logic [3:0]                        result_in,
  input  logic                              clear,
  input  logic                              hold,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             an,
  output logic                              dp,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   history_count,
  output logic [7:0]                        drop_count
);

  localparam int unsigned RefW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

  logic [3:0]            digit_q [NUM_DIGITS];
  logic [3:0]            digit_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] vld_q, vld_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            drop_q, drop_d;
  logic [RefW-1:0]       refresh_q;
  logic [IdxW-1:0]       scan_q;
  logic                  terminal;

  seg_code_t             seg_d, seg_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic                  dp_d, dp_q;

  always_comb begin
    digit_d = digit_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = '0;
      vld_d  = '0;
      cnt_d  = '0;
      drop_d = '0;
    end else if (result_valid) begin
      if (hold) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        for (int i = 1; i < NUM_DIGITS; i++) begin
          digit_d[i] = digit_q[i-1];
          vld_d[i]   = vld_q[i-1];
        end
        digit_d[0] = result_in;
        vld_d[0]   = 1'b1;
        if (cnt_q != CntW'(NUM_DIGITS)) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign terminal = (refresh_q == RefW'(REFRESH_DIV - 1));

  seg_decoder u_seg_decoder (
    .code   (digit_q[scan_q]),
    .valid  (vld_q[scan_q]),
    .hex_en (HEX_EN != 0),
    .seg    (seg_d)
  );

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (scan_q != IdxW'(i));
    dp_d = !((scan_q == '0) && vld_q[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      vld_q     <= '0;
      cnt_q     <= '0;
      drop_q    <= '0;
      refresh_q <= '0;
      scan_q    <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
      dp_q      <= 1'b1;
    end else begin
      digit_q <= digit_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      if (terminal) begin
        refresh_q <= '0;
        scan_q    <= (scan_q == IdxW'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      // seg/an/dp registered together so a digit switch never ghosts.
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg           = seg_q;
  assign an            = an_q;
  assign dp            = dp_q;
  assign history_count = cnt_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_result_display_mux.sv
// Scoreboard bench for result_display_mux: per-cycle expectations from a queue-based
// history model, checked by an independent monitor; two DUTs cover HEX_EN=0 and 1.
module tb_result_display_mux;

  localparam int N = 4;
  localparam int R = 4;

  typedef struct {
    logic [6:0] seg;
    logic [6:0] seg_hex;
    logic [3:0] an;
    logic       dp;
    logic [2:0] hc;
    logic [7:0] dc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       result_valid = 1'b0;
  logic [3:0] result_in = '0;
  logic       clear = 1'b0;
  logic       hold = 1'b0;
  logic       rst_req = 1'b0;

  logic [6:0] seg, seg_h;
  logic [3:0] an, an_h;
  logic       dp, dp_h;
  logic [2:0] history_count, hc_h;
  logic [7:0] drop_count, dc_h;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t expq[$];
  int   hist[$];
  int   drops = 0;
  int   k = 0;

  logic [6:0] pat [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 clk = ~clk;

  result_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .result_in(result_in),
    .clear(clear), .hold(hold), .seg(seg), .an(an), .dp(dp),
    .history_count(history_count), .drop_count(drop_count)
  );

  result_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_EN(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .result_in(result_in),
    .clear(clear), .hold(hold), .seg(seg_h), .an(an_h), .dp(dp_h),
    .history_count(hc_h), .drop_count(dc_h)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [6:0] expect_seg(input int idx, input bit hex);
    int code;
    if (idx >= hist.size()) return 7'h7F;
    code = hist[idx];
    if (code < 10 || hex) return pat[code];
    return 7'h7F;
  endfunction

  task automatic predict(input logic v, input logic [3:0] c, input logic h, input logic cl,
                         output exp_t e);
    int idx;
    logic [3:0] one;
    one = 4'b0001;
    if (!rst_n) begin
      hist.delete();
      drops = 0;
      k = 0;
      e = '{seg: 7'h7F, seg_hex: 7'h7F, an: 4'hF, dp: 1'b1, hc: 3'd0, dc: 8'd0};
      return;
    end
    // Display after this edge shows the digit scanned before it: floor(k/R) mod N.
    idx = (k / R) % N;
    k++;
    e.seg     = expect_seg(idx, 1'b0);
    e.seg_hex = expect_seg(idx, 1'b1);
    e.an      = ~(one << idx);
    e.dp      = !(idx == 0 && hist.size() > 0);
    if (cl) begin
      hist.delete();
      drops = 0;
    end else if (v) begin
      if (h) begin
        if (drops < 255) drops++;
      end else begin
        hist.push_front(int'(c));
        if (hist.size() > N) void'(hist.pop_back());
      end
    end
    e.hc = 3'(hist.size());
    e.dc = 8'(drops);
  endtask

  task automatic cycle(input logic v, input logic [3:0] c, input logic h, input logic cl);
    exp_t e;
    @(negedge clk);
    rst_n = rst_req;
    result_valid = v;
    result_in = c;
    hold = h;
    clear = cl;
    predict(v, c, h, cl, e);
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_seg_hex"}, 32'(seg_h), 32'h7F);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_hcount"}, 32'(history_count), 32'h0);
    chk({tag, "_dcount"}, 32'(drop_count), 32'h0);
  endtask

  // Monitor: compares one registered output set per active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("seg", 32'(seg), 32'(e.seg));
      chk("seg_hexdut", 32'(seg_h), 32'(e.seg_hex));
      chk("an", 32'(an), 32'(e.an));
      chk("an_hexdut", 32'(an_h), 32'(e.an));
      chk("dp", 32'(dp), 32'(e.dp));
      chk("history_count", 32'(history_count), 32'(e.hc));
      chk("drop_count", 32'(drop_count), 32'(e.dc));
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    idle(3);
    rst_req = 1'b1;
    idle(5);

    // 7, 2, 9 then a full scan pass
    cycle(1'b1, 4'd7, 1'b0, 1'b0);
    cycle(1'b1, 4'd2, 1'b0, 1'b0);
    cycle(1'b1, 4'd9, 1'b0, 1'b0);
    idle(2 * N * R + 3);

    // 1..5 evicts the oldest
    for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    idle(N * R + 3);

    // hold with 300 strobes saturates drop count
    for (int i = 0; i < 300; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    cycle(1'b1, 4'd6, 1'b0, 1'b0);
    idle(N * R + 2);

    // clear beats same-cycle strobe
    cycle(1'b1, 4'd3, 1'b0, 1'b1);
    idle(N * R + 2);

    // hex code 11
    cycle(1'b1, 4'd11, 1'b0, 1'b0);
    cycle(1'b1, 4'd14, 1'b0, 1'b0);
    idle(2 * N * R);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 59) == 0));
    end

    // full history, then async reset between edges
    for (int i = 0; i < N; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    idle(6);
    @(posedge clk);
    #3;
    rst_req = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    idle(3);
    rst_req = 1'b1;
    idle(2 * N * R);
    cycle(1'b1, 4'd8, 1'b0, 1'b0);
    idle(N * R + 2);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_display_mux.md
# result_display_mux

Multi-digit, time-multiplexed 7-segment result display. It is the parametrised successor to the single-digit result display in the top-level system controller. It captures each BNN classification result into a shift-register history of the last `NUM_DIGITS` results and scans them onto a common-segment display with per-digit anodes. It adds optional hex decode, a hold (freeze) control, and a saturating dropped-result counter, and sits between `bnn_interface` (`result_out`/`result_ready`) and the board's 7-segment pins.

## Interface
- `NUM_DIGITS`, 4: number of displayed digits and history depth; legal range 1..8.
- `REFRESH_DIV`, 100000: clk cycles per digit scan slot; minimum 2.
- `HEX_EN`, 0: 1 decodes codes 10..15 as A..F; 0 blanks them.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `result_valid` input 1: single-cycle strobe; `result_in` is valid.
- `result_in` input 4: classification code.
- `clear` input 1: synchronous clear of history and drop counter.
- `hold` input 1: level; while high, new results are not captured.
- `seg` output 7: segments {g..a}, active-low.
- `an` output NUM_DIGITS: digit anodes, active-low, one-hot-low.
- `dp` output 1: decimal point, active-low; marks the newest result.
- `history_count` output $clog2(NUM_DIGITS+1): number of valid history entries.
- `drop_count` output 8: results discarded under `hold`; saturates at 255.

## Operation
- History: `digit[0..NUM_DIGITS-1]` (4 bits each) plus `vld[0..NUM_DIGITS-1]`. Entry 0 is the newest.
- Capture (`result_valid && !hold && !clear`): `digit[0]<=result_in`, `vld[0]<=1`, `digit[i]<=digit[i-1]`, `vld[i]<=vld[i-1]`. The oldest entry is discarded. `history_count` increments and saturates at NUM_DIGITS.
- Drop (`result_valid && hold && !clear`): history is unchanged; `drop_count` increments and saturates at 255.
- `clear`: all `vld`<=0, `digit`<=0, `history_count`<=0, `drop_count`<=0. `clear` wins over a same-cycle `result_valid`; that result is lost and not counted.
- Scan: `refresh_cnt` is `$clog2(REFRESH_DIV)` bits wide and counts 0..REFRESH_DIV-1, then wraps. At terminal count, `scan_idx` advances and wraps NUM_DIGITS-1 -> 0. `clear` and `hold` never affect scanning.
- Decode of the scanned digit:
  - If `vld[scan_idx]`=0, segments are 7'h7F (blank).
  - Otherwise 0..9 use the standard active-low patterns (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10).
  - Codes 10..15 decode to A..F patterns if HEX_EN=1, else blank.
- `dp` is 0 only when `scan_idx`==0 and `vld[0]`=1.
- `an` drives bit `scan_idx` low and all other bits high.

## Timing
- Reset values:
  - `seg`=7'h7F, `an`=all 1s, `dp`=1.
  - `history_count`=0, `drop_count`=0.
  - `scan_idx`=0, `refresh_cnt`=0, all `vld`=0.
- Reset is asynchronous. Reset mid-scan or mid-capture blanks the outputs immediately. After release, scanning restarts at digit 0.
- Capture latency: strobe in cycle N updates history and `history_count` at the edge ending N, so they are visible in N+1.
- Output registration: `seg`/`an`/`dp` are registered one stage after the decode. They reflect `scan_idx`/history of the previous cycle, and `an` and `seg` always change on the same edge (no ghosting).
- A result is visible on the display at most NUM_DIGITS*REFRESH_DIV+2 cycles after its strobe.
- Back-to-back strobes on consecutive cycles are each captured; no minimum spacing.
- NUM_DIGITS=1: `scan_idx` is constant 0 and `an`=1'b0 after the first post-reset registered cycle.

## Structure
- Shared package `seg_pkg`:
  - `SEG_BLANK` constant.
  - Digit/hex pattern constants.
  - `seg_code_t` typedef (logic [6:0]).
- One natural sub-module, `seg_decoder`: combinational. Inputs: code [3:0], valid, hex_en. Output: `seg_code_t`.
- Top level holds the history shift register, counters and output registers.

## Test plan
- Reset, then 3 strobes with codes 7, 2, 9 (NUM_DIGITS=4, REFRESH_DIV=4) -> `history_count`=3. Scanning shows digit0=9 (7'h10, dp=0), digit1=2 (7'h24), digit2=7 (7'h78), digit3 blank (7'h7F); `an` cycles 1110, 1101, 1011, 0111 every 4 cycles.
- 5 strobes with codes 1..5 -> oldest (1) is evicted; digits show 5, 4, 3, 2; `history_count` stays at 4.
- Hold high, 300 strobes -> history unchanged, `drop_count`=255 (saturated); release hold, one strobe -> captured.
- `clear` and `result_valid` (code 3) in the same cycle -> all digits blank, `history_count`=0, `drop_count`=0.
- Code 11, HEX_EN=0 -> blank on that digit; with HEX_EN=1 -> 'b' pattern (7'h03).
- Assert `rst_n` low mid-scan with a full history -> `seg`=7'h7F, `an`=all 1s, `dp`=1 with no clock edge required. After release, `scan_idx` restarts at 0 and history is empty.
